// File: rtl/sd_cmd_controller.sv
// SPI-mode SD command engine: shifts out one 48-bit command frame on SD[1]
// and captures the 8-bit R1 response from SD[4], or reports 8'hFF on timeout.
`timescale 1ns/1ps
module sd_cmd_controller #(
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned NCR_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    inout  wire  [7:0]  SD,
    input  logic [47:0] cmd,
    input  logic        start,
    output logic        responseByte,
    output logic [7:0]  response
);

    localparam int unsigned DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned WAIT_SAMPLES = NCR_MAX * 8;
    localparam int unsigned WAIT_W       = $clog2(WAIT_SAMPLES + 1);
    localparam int unsigned BIT_W        = 6;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        WAIT = 3'd2,
        RECV = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;
    logic               cs_n_q, cs_n_d;
    logic [47:0]        shift_q, shift_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [7:0]         rx_q, rx_d;
    logic [7:0]         response_q, response_d;
    logic               strobe_q, strobe_d;
    logic               start_prev_q, start_prev_d;

    logic               miso_c;
    logic               tick_c;
    logic               trigger_c;

    // Only SCK, MOSI and CS_n are driven; SD[4] is left for the card.
    assign SD[0]   = sck_q;
    assign SD[1]   = mosi_q;
    assign SD[2]   = cs_n_q;
    assign SD[3]   = 1'bz;
    assign SD[7:5] = 3'bzzz;

    assign miso_c       = SD[4];
    assign responseByte = strobe_q;
    assign response     = response_q;

    assign tick_c    = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign trigger_c = start & ~start_prev_q & (state_q == IDLE);

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sck_q        <= 1'b0;
            mosi_q       <= 1'b1;
            cs_n_q       <= 1'b1;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            div_cnt_q    <= '0;
            rx_q         <= '0;
            response_q   <= 8'h00;
            strobe_q     <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sck_q        <= sck_d;
            mosi_q       <= mosi_d;
            cs_n_q       <= cs_n_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            div_cnt_q    <= div_cnt_d;
            rx_q         <= rx_d;
            response_q   <= response_d;
            strobe_q     <= strobe_d;
            start_prev_q <= start_prev_d;
        end
    end

    // Next-state logic; MISO is sampled while SCK is high, just before it falls
    always_comb begin
        state_d      = state_q;
        sck_d        = sck_q;
        mosi_d       = mosi_q;
        cs_n_d       = cs_n_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        div_cnt_d    = '0;
        rx_d         = rx_q;
        response_d   = response_q;
        strobe_d     = 1'b0;
        start_prev_d = start;

        case (state_q)
            IDLE: begin
                sck_d = 1'b0;
                if (trigger_c) begin
                    shift_d    = cmd;
                    cs_n_d     = 1'b0;
                    mosi_d     = cmd[47];
                    bit_cnt_d  = '0;
                    wait_cnt_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                div_cnt_d = tick_c ? '0 : div_cnt_q + DIV_W'(1);
                if (tick_c) begin
                    sck_d = ~sck_q;
                    if (sck_q) begin
                        if (bit_cnt_q == BIT_W'(47)) begin
                            mosi_d  = 1'b1;
                            state_d = WAIT;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            shift_d   = {shift_q[46:0], 1'b0};
                            mosi_d    = shift_q[46];
                        end
                    end
                end
            end
            WAIT: begin
                div_cnt_d = tick_c ? '0 : div_cnt_q + DIV_W'(1);
                if (tick_c) begin
                    sck_d = ~sck_q;
                    if (sck_q) begin
                        if (!miso_c) begin
                            rx_d      = 8'h00;
                            bit_cnt_d = BIT_W'(7);
                            state_d   = RECV;
                        end else if (wait_cnt_q == WAIT_W'(WAIT_SAMPLES - 1)) begin
                            response_d = 8'hFF;
                            strobe_d   = 1'b1;
                            cs_n_d     = 1'b1;
                            state_d    = DONE;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        end
                    end
                end
            end
            RECV: begin
                div_cnt_d = tick_c ? '0 : div_cnt_q + DIV_W'(1);
                if (tick_c) begin
                    sck_d = ~sck_q;
                    if (sck_q) begin
                        rx_d      = {rx_q[6:0], miso_c};
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                        if (bit_cnt_q == BIT_W'(1)) begin
                            response_d = {rx_q[6:0], miso_c};
                            strobe_d   = 1'b1;
                            cs_n_d     = 1'b1;
                            state_d    = DONE;
                        end
                    end
                end
            end
            DONE: begin
                sck_d   = 1'b0;
                cs_n_d  = 1'b1;
                mosi_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sd_cmd_controller.sv
// Directed bench for sd_cmd_controller: a simple card model answers on SD[4]
// and a monitor records MOSI bits, SCK pulses and response strobes.
`timescale 1ns/1ps
module tb_sd_cmd_controller;

    logic        clk;
    logic        rst_n;
    wire  [7:0]  sd;
    logic [47:0] cmd;
    logic        start;
    logic        resp_byte;
    logic [7:0]  resp;

    int total = 0;
    int bad   = 0;

    // card model controls: 0 = R1 after a delay, 1 = always 1, 2 = per-clock pattern
    int          miso_mode;
    int          r1_delay;
    logic [7:0]  r1_val;
    logic        pat_bit;
    logic        miso_drv;
    logic [11:0] pat_seq;

    // monitor state
    logic        sck_prev;
    logic        mosi_prev;
    int          rise_cnt;
    logic [47:0] mosi_cap;
    int          wait_mosi_low;
    int          unstable_cnt;
    int          strobe_cnt;
    int          sd4_bad;

    sd_cmd_controller #(.CLK_DIV(1), .NCR_MAX(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .SD           (sd),
        .cmd          (cmd),
        .start        (start),
        .responseByte (resp_byte),
        .response     (resp)
    );

    assign sd[4] = miso_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        miso_drv = 1'b1;
        case (miso_mode)
            0: begin
                if (rise_cnt >= 48 + r1_delay && rise_cnt < 56 + r1_delay)
                    miso_drv = r1_val[3'(7 - (rise_cnt - 48 - r1_delay))];
            end
            2: miso_drv = pat_bit;
            default: miso_drv = 1'b1;
        endcase
    end

    // Card-side view: MOSI captured on SCK rising edges while CS_n is low
    always @(posedge clk) begin
        sck_prev  <= sd[0];
        mosi_prev <= sd[1];
        if (sd[2]) begin
            rise_cnt <= 0;
        end else if (sd[0] && !sck_prev) begin
            rise_cnt <= rise_cnt + 1;
            if (rise_cnt < 48) mosi_cap <= {mosi_cap[46:0], sd[1]};
            else if (!sd[1]) wait_mosi_low <= wait_mosi_low + 1;
            if (sd[1] !== mosi_prev) unstable_cnt <= unstable_cnt + 1;
        end
        if (resp_byte) strobe_cnt <= strobe_cnt + 1;
        if (sd[4] !== miso_drv) sd4_bad <= sd4_bad + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raise start, keep it high for `hold` edges, wait for the strobe (bounded)
    task automatic run_txn(input logic [47:0] c, input int hold, output int lat);
        @(posedge clk);
        #1;
        cmd     = c;
        start   = 1'b1;
        pat_bit = pat_seq[11];
        lat     = 0;
        while (!resp_byte && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == hold) start = 1'b0;
            pat_bit = pat_seq[11 - (lat % 12)];
        end
        if (!resp_byte) check("strobe_timeout", 64'(lat), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_rb_low"}, 64'(resp_byte), 64'd0);
        check({tag, "_cs_high"}, 64'(sd[2]), 64'd1);
        check({tag, "_sck_low"}, 64'(sd[0]), 64'd0);
        check({tag, "_mosi_high"}, 64'(sd[1]), 64'd1);
    endtask

    initial begin
        int lat;
        int s0;
        rst_n         = 1'b0;
        cmd           = '0;
        start         = 1'b0;
        miso_mode     = 1;
        r1_delay      = 0;
        r1_val        = 8'hFF;
        pat_seq       = 12'b1011_0001_1101;
        pat_bit       = 1'b1;
        sck_prev      = 1'b0;
        mosi_prev     = 1'b1;
        rise_cnt      = 0;
        mosi_cap      = '0;
        wait_mosi_low = 0;
        unstable_cnt  = 0;
        strobe_cnt    = 0;
        sd4_bad       = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", 64'(sd[2]), 64'd1);
        check("rst_sck", 64'(sd[0]), 64'd0);
        check("rst_mosi", 64'(sd[1]), 64'd1);
        check("rst_rb", 64'(resp_byte), 64'd0);
        check("rst_resp", 64'(resp), 64'h00);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // CMD0: 16 busy samples then R1 = 0x01
        miso_mode = 0; r1_delay = 16; r1_val = 8'h01;
        s0 = strobe_cnt;
        run_txn(48'h4000_0000_0095, 1, lat);
        check("cmd0_lat", 64'(lat), 64'd145);
        check("cmd0_resp", 64'(resp), 64'h01);
        check("cmd0_mosi", 64'(mosi_cap), 64'h4000_0000_0095);
        check("cmd0_rises", 64'(rise_cnt), 64'd72);
        check_idle("cmd0");
        repeat (3) @(posedge clk);
        check("cmd0_one_strobe", 64'(strobe_cnt - s0), 64'd1);

        // Alternating pattern, immediate response
        r1_delay = 0; r1_val = 8'h05;
        run_txn(48'hAAAA_AAAA_AAAA, 1, lat);
        check("alt_lat", 64'(lat), 64'd113);
        check("alt_resp", 64'(resp), 64'h05);
        check("alt_mosi", 64'(mosi_cap), 64'hAAAA_AAAA_AAAA);
        check("alt_rises", 64'(rise_cnt), 64'd56);
        check("alt_stable", 64'(unstable_cnt), 64'd0);
        check_idle("alt");

        // Timeout: card never answers
        miso_mode = 1;
        s0 = strobe_cnt;
        run_txn(48'h7A00_0000_00FD, 1, lat);
        check("to_lat", 64'(lat), 64'd225);
        check("to_resp", 64'(resp), 64'hFF);
        check("to_rises", 64'(rise_cnt), 64'd112);
        check_idle("to");
        repeat (3) @(posedge clk);
        check("to_one_strobe", 64'(strobe_cnt - s0), 64'd1);

        // Start held 40 cycles, then held through completion and beyond
        miso_mode = 0; r1_delay = 3; r1_val = 8'h3C;
        s0 = strobe_cnt;
        run_txn(48'h5100_0000_0055, 40, lat);
        check("hold40_lat", 64'(lat), 64'd119);
        check("hold40_resp", 64'(resp), 64'h3C);
        repeat (60) @(posedge clk);
        check("hold40_one_strobe", 64'(strobe_cnt - s0), 64'd1);
        r1_val = 8'h12;
        s0 = strobe_cnt;
        run_txn(48'h4800_0001_AA87, 100000, lat);
        check("holdlong_lat", 64'(lat), 64'd119);
        check("holdlong_resp", 64'(resp), 64'h12);
        repeat (200) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        check("holdlong_one_strobe", 64'(strobe_cnt - s0), 64'd1);

        // Reset in the middle of the command phase
        s0 = strobe_cnt;
        @(posedge clk); #1; cmd = 48'h4000_0000_0095; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_cs", 64'(sd[2]), 64'd1);
        check("mid_rst_sck", 64'(sd[0]), 64'd0);
        check("mid_rst_resp", 64'(resp), 64'h00);
        check("mid_rst_rb", 64'(resp_byte), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        check("mid_rst_no_strobe", 64'(strobe_cnt - s0), 64'd0);
        r1_delay = 16; r1_val = 8'h01;
        run_txn(48'h4000_0000_0095, 1, lat);
        check("post_rst_lat", 64'(lat), 64'd145);
        check("post_rst_resp", 64'(resp), 64'h01);
        check("post_rst_mosi", 64'(mosi_cap), 64'h4000_0000_0095);

        // Per-clock MISO pattern 101100011101: first zero at wait sample 1
        miso_mode = 2;
        run_txn(48'h5800_0000_0001, 1, lat);
        check("pat_lat", 64'(lat), 64'd115);
        check("pat_resp", 64'(resp), 64'h2C);
        check_idle("pat");

        check("wait_mosi_high", 64'(wait_mosi_low), 64'd0);
        check("mosi_stable", 64'(unstable_cnt), 64'd0);
        check("sd4_undriven", 64'(sd4_bad), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
